// File: rtl/cost_vol_packer_pkg.sv
// -----------------------------------------------------------------------------
// cost_vol_packer_pkg
// Shared stereo-pipeline constants for the cost volume packer:
//   MAXDISPARITY  - number of disparity costs that make up one pixel
//   LPDI_WIDTH    - packed (saturated) cost width per disparity
//   COSTIN_WIDTH  - width of the serial aggregated cost entering the packer
//   OUTPUTDATAWID - packed volume width, one slot per disparity plus SOF bit
//   CNT_WIDTH     - width of the disparity slot counter
// Also holds the packer FSM state encoding.
// -----------------------------------------------------------------------------
package cost_vol_packer_pkg;

  localparam int MAXDISPARITY  = 64;
  localparam int LPDI_WIDTH    = 8;
  localparam int COSTIN_WIDTH  = 10;
  localparam int OUTPUTDATAWID = MAXDISPARITY * LPDI_WIDTH + 1;
  localparam int CNT_WIDTH     = $clog2(MAXDISPARITY);

  // WAIT_SOF: hunting for the first cost of a frame.
  // FILL:     assembling pixels slot by slot.
  typedef enum logic [0:0] {
    ST_WAIT_SOF = 1'b0,
    ST_FILL     = 1'b1
  } state_e;

endpackage : cost_vol_packer_pkg

// File: rtl/cost_vol_packer_cost_sat.sv
// -----------------------------------------------------------------------------
// cost_sat
// Combinational clamp of a wide aggregated cost onto the packed cost width.
// Any value that does not fit in LPDI_WIDTH bits becomes all-ones; values
// that fit pass through unchanged.
//
// Ports
//   cost_i  [COSTIN_WIDTH-1:0]  incoming aggregated cost
//   cost_o  [LPDI_WIDTH-1:0]    saturated cost
// -----------------------------------------------------------------------------
module cost_sat #(
  parameter int COSTIN_WIDTH = 10,
  parameter int LPDI_WIDTH   = 8
) (
  input  logic [COSTIN_WIDTH-1:0] cost_i,
  output logic [LPDI_WIDTH-1:0]   cost_o
);

  // Any set bit above the packed width means the cost is out of range.
  logic over_s;
  assign over_s = |cost_i[COSTIN_WIDTH-1:LPDI_WIDTH];

  // Clamp to the largest representable packed cost on overflow.
  always_comb begin
    if (over_s) begin
      cost_o = '1;
    end else begin
      cost_o = cost_i[LPDI_WIDTH-1:0];
    end
  end

endmodule : cost_sat

// File: rtl/cost_vol_packer.sv
// -----------------------------------------------------------------------------
// cost_vol_packer
// Collects a serial stream of per-disparity costs (disparity 0 first) into a
// packed per-pixel cost volume. Each cost is saturated to LPDI_WIDTH bits and
// written into a fill buffer; once the last disparity arrives the completed
// pixel plus its start-of-frame flag is copied into the output register and
// announced with a one-cycle strobe. The output register is separate from the
// fill buffer, so the next pixel can be assembled while the previous one is
// still being consumed.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset, overrides everything
//   en          global enable; low freezes all state and blocks transfers
//   cost_valid  cost_in / cost_sof are valid this cycle
//   cost_in     aggregated cost of the current disparity
//   cost_sof    start of frame, only with disparity 0 of a frame's first pixel
//   cost_ready  transfer acceptance (en while not in reset)
//   LPDo        packed pixel: slot k holds disparity k, MSB is the SOF flag
//   pixelEN     one-cycle strobe, LPDo has just been loaded with a new pixel
//   sync_err    sticky: a start of frame interrupted a partially filled pixel
// -----------------------------------------------------------------------------
module cost_vol_packer #(
  parameter int MAXDISPARITY  = cost_vol_packer_pkg::MAXDISPARITY,
  parameter int LPDI_WIDTH    = cost_vol_packer_pkg::LPDI_WIDTH,
  parameter int COSTIN_WIDTH  = cost_vol_packer_pkg::COSTIN_WIDTH,
  parameter int OUTPUTDATAWID = MAXDISPARITY * LPDI_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cost_valid,
  input  logic [COSTIN_WIDTH-1:0]  cost_in,
  input  logic                     cost_sof,
  output logic                     cost_ready,
  output logic [OUTPUTDATAWID-1:0] LPDo,
  output logic                     pixelEN,
  output logic                     sync_err
);

  import cost_vol_packer_pkg::*;

  localparam int                CNT_W     = $clog2(MAXDISPARITY);
  localparam int                FILL_W    = MAXDISPARITY * LPDI_WIDTH;
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(MAXDISPARITY - 1);
  localparam logic [CNT_W-1:0]  ONE_SLOT  = CNT_W'(1);

  state_e                   state_q;
  logic [CNT_W-1:0]         count_q;
  logic [FILL_W-1:0]        fill_q;
  logic                     pix_sof_q;
  logic [OUTPUTDATAWID-1:0] lpdo_q;
  logic                     pixel_en_q;
  logic                     sync_err_q;

  logic [LPDI_WIDTH-1:0]    cost_sat_s;
  logic [FILL_W-1:0]        full_pixel_s;

  cost_sat #(
    .COSTIN_WIDTH (COSTIN_WIDTH),
    .LPDI_WIDTH   (LPDI_WIDTH)
  ) u_cost_sat (
    .cost_i (cost_in),
    .cost_o (cost_sat_s)
  );

  // Acceptance is purely the enable gated by reset; there is no back-pressure
  // from the output side because the output register is double buffered.
  assign cost_ready = en & ~rst;

  // The last disparity goes straight into the output register, so merge it
  // with the fill buffer here instead of writing it to the buffer first.
  always_comb begin
    full_pixel_s = fill_q;
    full_pixel_s[LAST_SLOT*LPDI_WIDTH +: LPDI_WIDTH] = cost_sat_s;
  end

  // Packer FSM: slot counter, fill buffer, output register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT_SOF;
      count_q    <= '0;
      fill_q     <= '0;
      pix_sof_q  <= 1'b0;
      lpdo_q     <= '0;
      pixel_en_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else if (!en) begin
      // Frozen: only the strobe is forced low so a pixel is never announced twice.
      pixel_en_q <= 1'b0;
    end else begin
      pixel_en_q <= 1'b0;
      if (cost_valid) begin
        case (state_q)
          ST_WAIT_SOF: begin
            // Everything before the first start of frame is dropped.
            if (cost_sof) begin
              fill_q[LPDI_WIDTH-1:0] <= cost_sat_s;
              pix_sof_q              <= 1'b1;
              count_q                <= ONE_SLOT;
              state_q                <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (cost_sof) begin
              // A start of frame restarts the pixel; if slots were already
              // filled the partial pixel is lost and the error is latched.
              if (count_q != '0) begin
                sync_err_q <= 1'b1;
              end
              fill_q[LPDI_WIDTH-1:0] <= cost_sat_s;
              pix_sof_q              <= 1'b1;
              count_q                <= ONE_SLOT;
            end else if (count_q == LAST_SLOT) begin
              lpdo_q     <= {pix_sof_q, full_pixel_s};
              pixel_en_q <= 1'b1;
              pix_sof_q  <= 1'b0;
              count_q    <= '0;
            end else begin
              fill_q[count_q*LPDI_WIDTH +: LPDI_WIDTH] <= cost_sat_s;
              count_q                                  <= count_q + ONE_SLOT;
            end
          end
          default: begin
            // Unreachable encoding: resynchronise on the next start of frame.
            state_q   <= ST_WAIT_SOF;
            count_q   <= '0;
            pix_sof_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign LPDo     = lpdo_q;
  assign pixelEN  = pixel_en_q;
  assign sync_err = sync_err_q;

endmodule : cost_vol_packer

// File: tb/tb_cost_vol_packer.sv
module tb_cost_vol_packer;
  import cost_vol_packer_pkg::*;

  localparam int ND = MAXDISPARITY;
  localparam int W  = LPDI_WIDTH;
  localparam int OW = OUTPUTDATAWID;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    cost_valid;
  logic [COSTIN_WIDTH-1:0] cost_in;
  logic                    cost_sof;
  logic                    cost_ready;
  logic [OW-1:0]           LPDo;
  logic                    pixelEN;
  logic                    sync_err;

  cost_vol_packer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cost_valid (cost_valid),
    .cost_in    (cost_in),
    .cost_sof   (cost_sof),
    .cost_ready (cost_ready),
    .LPDo       (LPDo),
    .pixelEN    (pixelEN),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            pass_cnt = 0;
  int            fail_cnt = 0;
  logic [OW-1:0] last_px  = '0;

  // reference model state
  bit            m_fill;
  int            m_cnt;
  logic [W-1:0]  m_buf [ND];
  bit            m_sof;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] sat(input logic [COSTIN_WIDTH-1:0] c);
    return (c > 10'd255) ? 8'd255 : c[W-1:0];
  endfunction

  // monitor: every strobe must match the oldest expected pixel, at its cycle
  always @(posedge clk) begin
    #2;
    if (pixelEN === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixelEN", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel_data", LPDo, mon_e.data);
        check("pixel_cycle", cyc, mon_e.cyc);
        last_px = mon_e.data;
      end
    end
  end

  // drive one cycle at the falling edge, update the model, wait a cycle
  task automatic step(input logic v, input logic [COSTIN_WIDTH-1:0] c, input logic s, input logic e);
    logic [OW-1:0] px;
    en = e; cost_valid = v; cost_in = c; cost_sof = s;
    if (v && e) begin
      if (!m_fill) begin
        if (s) begin
          m_buf[0] = sat(c); m_sof = 1'b1; m_cnt = 1; m_fill = 1'b1;
        end
      end else if (s) begin
        m_buf[0] = sat(c); m_sof = 1'b1; m_cnt = 1;
      end else begin
        m_buf[m_cnt] = sat(c);
        if (m_cnt == ND - 1) begin
          px = '0;
          px[OW-1] = m_sof;
          for (int k = 0; k < ND; k++) px[k*W +: W] = m_buf[k];
          exp_q.push_back('{px, cyc + 1});
          m_sof = 1'b0;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; cost_valid = 1'b1; cost_sof = 1'b0;
    m_fill = 1'b0; m_cnt = 0; m_sof = 1'b0;
    @(negedge clk);
    check("rst_LPDo", LPDo, 0);
    check("rst_pixelEN", pixelEN, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_cost_ready", cost_ready, 0);
    rst = 1'b0;
    last_px = '0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cost_valid = 1'b0; cost_in = '0; cost_sof = 1'b0;
    m_fill = 1'b0; m_cnt = 0; m_sof = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();
    step(1'b0, 10'd0, 1'b0, 1'b1);
    check("cost_ready_en", cost_ready, 1);

    // costs before any SOF are discarded, then a ramp pixel with SOF
    for (int k = 0; k < 10; k++) step(1'b1, 10'(500 + k), 1'b0, 1'b1);
    for (int k = 0; k < ND; k++) step(1'b1, 10'(k), (k == 0), 1'b1);
    step(1'b0, 10'd0, 1'b0, 1'b1);
    check("ramp_sof_bit", LPDo[OW-1], 1);
    check("ramp_slot0", LPDo[0 +: W], 8'd0);
    check("ramp_slot10", LPDo[10*W +: W], 8'd10);
    check("ramp_slot63", LPDo[63*W +: W], 8'd63);
    check("ramp_no_err", sync_err, 0);

    // back-to-back pixels 100 then 200, new SOF at a pixel boundary
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < ND; k++) begin
        step(1'b1, (p == 0) ? 10'd100 : 10'd200, (p == 0 && k == 0), 1'b1);
        if (p == 1 && k == 20) check("hold_during_fill", LPDo, last_px);
      end
    end
    step(1'b0, 10'd0, 1'b0, 1'b1);
    check("b2b_sof_bit2", LPDo[OW-1], 0);
    check("b2b_slot37", LPDo[37*W +: W], 8'd200);
    check("b2b_boundary_sof_no_err", sync_err, 0);
    repeat (3) step(1'b0, 10'd0, 1'b0, 1'b1);
    check("hold_idle", LPDo, last_px);

    // saturation at disparities 5,6 and exact 255 at 7
    for (int k = 0; k < ND; k++)
      step(1'b1, (k == 5) ? 10'd1023 : (k == 6) ? 10'd256 : (k == 7) ? 10'd255 : 10'(k), 1'b0, 1'b1);
    step(1'b0, 10'd0, 1'b0, 1'b1);
    check("sat_slot4", LPDo[4*W +: W], 8'd4);
    check("sat_slot5", LPDo[5*W +: W], 8'd255);
    check("sat_slot6", LPDo[6*W +: W], 8'd255);
    check("sat_slot7", LPDo[7*W +: W], 8'd255);

    // SOF at disparity 30 drops the partial pixel and flags sync_err
    for (int k = 0; k < 30; k++) step(1'b1, 10'd50, 1'b0, 1'b1);
    step(1'b1, 10'd77, 1'b1, 1'b1);
    check("midsof_sync_err", sync_err, 1);
    for (int k = 1; k < ND; k++) step(1'b1, 10'd60, 1'b0, 1'b1);
    step(1'b0, 10'd0, 1'b0, 1'b1);
    check("midsof_sof_bit", LPDo[OW-1], 1);
    check("midsof_slot0", LPDo[0 +: W], 8'd77);
    check("midsof_slot1", LPDo[1*W +: W], 8'd60);

    // en low for 10 cycles mid-pixel with cost_valid high
    for (int k = 0; k < 20; k++) step(1'b1, 10'(k + 1), 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 10'd999, 1'b0, 1'b0);
      check("en_low_cost_ready", cost_ready, 0);
    end
    for (int k = 20; k < ND; k++) step(1'b1, 10'(k + 1), 1'b0, 1'b1);
    step(1'b0, 10'd0, 1'b0, 1'b1);
    check("en_low_sticky_err", sync_err, 1);

    // reset at disparity 40, then SOF-less costs give no pixel
    for (int k = 0; k < 40; k++) step(1'b1, 10'd9, 1'b0, 1'b1);
    do_reset();
    for (int k = 0; k < ND; k++) step(1'b1, 10'd33, 1'b0, 1'b1);
    check("post_rst_LPDo_zero", LPDo, 0);
    for (int k = 0; k < ND; k++) step(1'b1, 10'(k + 100), (k == 0), 1'b1);
    repeat (3) step(1'b0, 10'd0, 1'b0, 1'b1);
    check("final_slot3", LPDo[3*W +: W], 8'd103);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule : tb_cost_vol_packer
